// File: rtl/calc_seq_pkg.sv
// Shared types for the calc engine sequencer: FSM states, lane geometry, latched job config.
// Widths are fixed here so the config struct can be shared by the top and the bench.
package calc_seq_pkg;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 16;
  localparam int SHIFT_W = 3;
  localparam int LANES   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] stride_a;
    logic [ADDR_W-1:0] stride_s;
    logic [CNT_W-1:0]  k_steps;
    logic [CNT_W-1:0]  n_tiles;
  } cfg_t;

endpackage

// File: rtl/calc_seq_if.sv
// Engine-side bundle: step addresses/controls toward the calc engine, result write handshake.
// master = sequencer, slave = engine and result sink.
interface calc_seq_if;
  import calc_seq_pkg::*;

  logic [ADDR_W-1:0]              addr_A;
  logic [ADDR_W-1:0]              addr_S;
  logic [ADDR_W-1:0]              addr_B;
  logic                           eng_start;
  logic                           acc_init;
  logic [LANES-1:0][SHIFT_W-1:0]  shift_amt;
  logic                           wr_en;
  logic                           wr_ready;

  modport master (
    output addr_A, addr_S, addr_B, eng_start, acc_init, shift_amt, wr_en,
    input  wr_ready
  );

  modport slave (
    input  addr_A, addr_S, addr_B, eng_start, acc_init, shift_amt, wr_en,
    output wr_ready
  );
endinterface

// File: rtl/calc_seq_addr_gen.sv
// A/S/B address registers for the sequencer; updates land one cycle after the control strobe.
// No backpressure of its own: the FSM only strobes step/tile_next when the move is committed.
module calc_seq_addr_gen
  import calc_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              wrap,
  input  logic              tile_next,
  input  logic              chunk_next,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_s,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_s,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_s,
  output logic [ADDR_W-1:0] addr_b
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_a <= '0;
      addr_s <= '0;
      addr_b <= '0;
    end else if (load) begin
      addr_a <= base_a;
      addr_s <= base_s;
      addr_b <= base_b;
    end else begin
      if (step) begin
        addr_s <= addr_s + stride_s;
        if (wrap) addr_a <= addr_a + stride_a;
      end
      // A stays contiguous: a partially used chunk is skipped so the next tile starts fresh.
      if (tile_next) begin
        addr_b <= addr_b + ADDR_W'(1);
        addr_s <= base_s;
        if (chunk_next) addr_a <= addr_a + stride_a;
      end
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Job sequencer: first eng_start 1 cycle after start, k_steps+PIPE_LAT+1 cycles per tile; wr_ready low holds WRITE.
// CALC_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module calc_seq_ctrl
  import calc_seq_pkg::*;
#(
  parameter int PLANES   = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_base_s,
  input  logic [ADDR_W-1:0] cfg_base_b,
  input  logic [ADDR_W-1:0] cfg_stride_a,
  input  logic [ADDR_W-1:0] cfg_stride_s,
  input  logic [CNT_W-1:0]  cfg_k_steps,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  calc_seq_if.master        eng,
  output logic              busy,
  output logic              done
`ifdef CALC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e               state, state_nxt;
  cfg_t                 cfg_in, cfg_q, cfg_cur;
  logic [CNT_W-1:0]     tile, k;
  logic [SHIFT_W-1:0]   plane;
  logic [DRAIN_W-1:0]   drain;
  logic                 accept, step_en, wr_fire, wrap, last_step, last_tile, zero_job;

  assign cfg_in = '{base_a: cfg_base_a, base_s: cfg_base_s, base_b: cfg_base_b,
                    stride_a: cfg_stride_a, stride_s: cfg_stride_s,
                    k_steps: cfg_k_steps, n_tiles: cfg_n_tiles};
  // In IDLE the live ports feed the load path; afterwards only the latched copy is visible.
  assign cfg_cur = (state == IDLE) ? cfg_in : cfg_q;

  assign accept    = (state == IDLE) && start;
  assign step_en   = (state == STEP);
  assign wr_fire   = (state == WRITE) && eng.wr_ready;
  assign wrap      = (plane == SHIFT_W'(PLANES - 1));
  assign last_step = (k == cfg_cur.k_steps - CNT_W'(1));
  assign last_tile = (tile == cfg_cur.n_tiles - CNT_W'(1));
  assign zero_job  = (cfg_cur.k_steps == '0) || (cfg_cur.n_tiles == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    eng.eng_start = 1'b0;
    eng.acc_init  = 1'b0;
    eng.shift_amt = '0;
    eng.wr_en     = 1'b0;
    busy          = (state != IDLE);
    done          = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = zero_job ? FIN : STEP;
      STEP: begin
        eng.eng_start = 1'b1;
        eng.acc_init  = (k == '0);
        eng.shift_amt = {LANES{plane}};
        if (last_step) state_nxt = DRAIN;
      end
      DRAIN: if (drain == '0) state_nxt = WRITE;
      WRITE: begin
        eng.wr_en = 1'b1;
        if (eng.wr_ready) state_nxt = last_tile ? FIN : STEP;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      tile  <= '0;
      k     <= '0;
      plane <= '0;
      drain <= '0;
    end else begin
      if (accept) begin
        cfg_q <= cfg_in;
        tile  <= '0;
        k     <= '0;
        plane <= '0;
      end
      if (step_en) begin
        k     <= k + CNT_W'(1);
        plane <= wrap ? '0 : plane + SHIFT_W'(1);
        drain <= DRAIN_W'(PIPE_LAT - 1);
      end
      if (state == DRAIN) drain <= drain - DRAIN_W'(1);
      if (wr_fire) begin
        tile  <= tile + CNT_W'(1);
        k     <= '0;
        plane <= '0;
      end
    end
  end

  calc_seq_addr_gen u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       (step_en),
    .wrap       (wrap),
    .tile_next  (wr_fire),
    .chunk_next (plane != '0),
    .base_a     (cfg_cur.base_a),
    .base_s     (cfg_cur.base_s),
    .base_b     (cfg_cur.base_b),
    .stride_a   (cfg_cur.stride_a),
    .stride_s   (cfg_cur.stride_s),
    .addr_a     (eng.addr_A),
    .addr_s     (eng.addr_S),
    .addr_b     (eng.addr_B)
  );

`ifdef CALC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state == WRITE && !eng.wr_ready && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
